// File: rtl/dbg_uart_pkg.sv
// Shared types and sizing helpers for the debug UART transmitter and its FIFO.
package dbg_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEF_BAUD_DIV   = 434;
    localparam int DEF_FIFO_DEPTH = 4;

    // Baud counter spans 0..div-1; keep at least one bit for degenerate divisors.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Small byte FIFO with show-ahead output; writes while full are dropped and flagged.
module dbg_fifo
    import dbg_uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       ovf_set
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [7:0]    mem [DEPTH];
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // full is the registered-pointer view, so a same-cycle pop never rescues a write.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign ovf_set = wr_en && full;

    assign dout = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/dbg_uart_tx.sv
// Debug UART transmitter: queues debug bytes and sends them 8N1, LSB first,
// with back-to-back frames whenever the queue still holds data at a stop bit.
module dbg_uart_tx
    import dbg_uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEF_BAUD_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dbg_data,
    input  logic       dbg_tx,
    input  logic       clr_ovf,
    output logic       TX,
    output logic       dbg_done,
    output logic       full,
    output logic       busy,
    output logic       ovf
);

    localparam int            CW        = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] baud_reg;
    logic [CW-1:0] baud_next;
    logic [2:0]    bit_reg;
    logic [2:0]    bit_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          tx_reg;
    logic          tx_next;
    logic          done_reg;
    logic          done_next;
    logic          ovf_reg;

    logic          pop;
    logic          bit_end;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic          ovf_set;

    dbg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (dbg_tx),
        .din     (dbg_data),
        .rd_en   (pop),
        .dout    (fifo_dout),
        .full    (full),
        .empty   (fifo_empty),
        .ovf_set (ovf_set)
    );

    assign bit_end = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_dout;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase
    end

    // Line level and done pulse are derived from the next state so both are
    // plain flops yet line up exactly with the state they describe.
    always_comb begin
        tx_next = 1'b1;
        if (state_next == START) begin
            tx_next = 1'b0;
        end else if (state_next == DATA) begin
            tx_next = shift_next[0];
        end
        done_next = (state_next == STOP) && (baud_next == BAUD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
        end
    end

    // A dropped write outranks a same-cycle clear so no overflow goes unseen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (ovf_set) begin
            ovf_reg <= 1'b1;
        end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
        end
    end

    assign TX       = tx_reg;
    assign dbg_done = done_reg;
    assign ovf      = ovf_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dbg_uart_tx.sv
// Bench for dbg_uart_tx: exact frame timing on a 434-divisor instance, and a
// line-decoding receiver on an 8-divisor instance for queueing/overflow/reset cases.
module tb_dbg_uart_tx;

    localparam int SLOW_DIV = 434;
    localparam int FAST_DIV = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       dbg_tx   = 1'b0;
    logic       clr_ovf  = 1'b0;
    logic [7:0] dbg_data = 8'h00;

    logic s_tx, s_done, s_full, s_busy, s_ovf;
    logic f_tx, f_done, f_full, f_busy, f_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] rx_q[$];
    int         rst_count = 0;

    logic [7:0] mon_byte;
    logic       mon_stop;
    int         mon_snap;

    always #5 clk = ~clk;

    dbg_uart_tx #(.BAUD_DIV(SLOW_DIV), .FIFO_DEPTH(4)) u_slow (
        .clk(clk), .rst_n(rst_n), .dbg_data(dbg_data), .dbg_tx(dbg_tx), .clr_ovf(clr_ovf),
        .TX(s_tx), .dbg_done(s_done), .full(s_full), .busy(s_busy), .ovf(s_ovf)
    );

    dbg_uart_tx #(.BAUD_DIV(FAST_DIV), .FIFO_DEPTH(4)) u_fast (
        .clk(clk), .rst_n(rst_n), .dbg_data(dbg_data), .dbg_tx(dbg_tx), .clr_ovf(clr_ovf),
        .TX(f_tx), .dbg_done(f_done), .full(f_full), .busy(f_busy), .ovf(f_ovf)
    );

    always @(negedge rst_n) rst_count <= rst_count + 1;

    // Receiver on the fast line: mid-bit sampling; frames hit by a reset are discarded.
    always begin
        @(negedge f_tx);
        if (rst_n) begin
            mon_snap = rst_count;
            repeat (FAST_DIV / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (FAST_DIV) @(posedge clk);
                #1;
                mon_byte[i] = f_tx;
            end
            repeat (FAST_DIV) @(posedge clk);
            #1;
            mon_stop = f_tx;
            if (rst_count == mon_snap && rst_n) begin
                checks++;
                if (mon_stop !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit: got %b expected 1 (byte %02h)", mon_stop, mon_byte);
                end
                rx_q.push_back(mon_byte);
                $display("rx byte %02h", mon_byte);
            end
        end
    end

    // Expected line level e edges after the first write strobe was raised.
    function automatic logic frame_tx(input int e, input int div);
        int k, f, b;
        if (e < 2) return 1'b1;
        k = (e - 2) / div;
        f = k / 10;
        b = k % 10;
        if (f >= exp_bytes.size()) return 1'b1;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return exp_bytes[f][b-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fast_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!f_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({s_tx, s_done, s_full, s_busy, s_ovf} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_slow: got %b expected 10000", {s_tx, s_done, s_full, s_busy, s_ovf});
        end
        checks++;
        if ({f_tx, f_done, f_full, f_busy, f_ovf} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_fast: got %b expected 10000", {f_tx, f_done, f_full, f_busy, f_ovf});
        end
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({f_tx, f_busy, s_tx, s_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 1010", {f_tx, f_busy, s_tx, s_busy});
        end
        $display("test_reset done");
    endtask

    task automatic test_single_byte();
        int done_cnt, done_at;
        exp_bytes = '{8'hA5};
        done_cnt  = 0;
        done_at   = -1;
        dbg_data  = 8'hA5;
        dbg_tx    = 1'b1;
        for (int e = 1; e <= 10 * SLOW_DIV + 5; e++) begin
            tick();
            if (e == 1) dbg_tx = 1'b0;
            if (e <= 2 || (e < 2 + 10 * SLOW_DIV &&
                ((e - 2) % SLOW_DIV == 0 || (e - 2) % SLOW_DIV == SLOW_DIV - 1))) begin
                checks++;
                if (s_tx !== frame_tx(e, SLOW_DIV)) begin
                    errors++;
                    $display("FAIL single_tx: edge %0d got %b expected %b", e, s_tx, frame_tx(e, SLOW_DIV));
                end
            end
            if (s_done === 1'b1) begin
                done_cnt++;
                done_at = e;
            end
            if (e == 4341 || e == 4342) begin
                checks++;
                if (s_busy !== (e == 4341)) begin
                    errors++;
                    $display("FAIL single_busy: edge %0d got %b expected %b", e, s_busy, (e == 4341));
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != 4341) begin
            errors++;
            $display("FAIL single_done: got %0d pulses at %0d expected 1 at 4341", done_cnt, done_at);
        end
        $display("test_single_byte done: pulses=%0d at edge %0d", done_cnt, done_at);
    endtask

    task automatic test_back_to_back();
        int done_edges[$];
        exp_bytes = '{8'h00, 8'hFF, 8'h55};
        dbg_data  = 8'h00;
        dbg_tx    = 1'b1;
        for (int e = 1; e <= 30 * SLOW_DIV + 5; e++) begin
            tick();
            if (e == 1) dbg_data = 8'hFF;
            if (e == 2) dbg_data = 8'h55;
            if (e == 3) dbg_tx = 1'b0;
            if (e <= 2 || (e < 2 + 30 * SLOW_DIV &&
                ((e - 2) % SLOW_DIV == 0 || (e - 2) % SLOW_DIV == SLOW_DIV - 1))) begin
                checks++;
                if (s_tx !== frame_tx(e, SLOW_DIV)) begin
                    errors++;
                    $display("FAIL b2b_tx: edge %0d got %b expected %b", e, s_tx, frame_tx(e, SLOW_DIV));
                end
            end
            if (s_done === 1'b1) done_edges.push_back(e);
            if (e == 13021 || e == 13022) begin
                checks++;
                if (s_busy !== (e == 13021)) begin
                    errors++;
                    $display("FAIL b2b_busy: edge %0d got %b expected %b", e, s_busy, (e == 13021));
                end
            end
        end
        checks++;
        if (done_edges.size() != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 3", done_edges.size());
        end
        for (int i = 0; i < done_edges.size() && i < 3; i++) begin
            checks++;
            if (done_edges[i] != 4341 + 4340 * i) begin
                errors++;
                $display("FAIL b2b_done_edge: pulse %0d got %0d expected %0d", i, done_edges[i], 4341 + 4340 * i);
            end
        end
        $display("test_back_to_back done: pulses=%0d", done_edges.size());
    endtask

    task automatic test_overflow();
        bit ok;
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            dbg_data = 8'h10 + 8'(i);
            dbg_tx   = 1'b1;
            tick();
            if (i == 4) begin
                checks++;
                if ({f_full, f_ovf} !== 2'b10) begin
                    errors++;
                    $display("FAIL ovf_before_drop: got full,ovf=%b expected 10", {f_full, f_ovf});
                end
            end
        end
        dbg_tx = 1'b0;
        checks++;
        if ({f_full, f_ovf} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_after_drop: got full,ovf=%b expected 11", {f_full, f_ovf});
        end
        wait_fast_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_idle_timeout: got busy expected idle");
        end
        checks++;
        if (rx_q.size() != 5) begin
            errors++;
            $display("FAIL ovf_rx_count: got %0d expected 5", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            checks++;
            if (rx_q[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL ovf_rx_byte: idx %0d got %02h expected %02h", i, rx_q[i], 8'h10 + 8'(i));
            end
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (f_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", f_ovf);
        end
        $display("test_overflow done: rx=%0d", rx_q.size());
    endtask

    task automatic test_set_clear();
        bit ok;
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            dbg_data = 8'h20 + 8'(i);
            dbg_tx   = 1'b1;
            tick();
        end
        checks++;
        if ({f_full, f_ovf} !== 2'b10) begin
            errors++;
            $display("FAIL setclr_prefill: got full,ovf=%b expected 10", {f_full, f_ovf});
        end
        dbg_data = 8'hEE;
        clr_ovf  = 1'b1;
        tick();
        dbg_tx  = 1'b0;
        clr_ovf = 1'b0;
        checks++;
        if (f_ovf !== 1'b1) begin
            errors++;
            $display("FAIL setclr_ovf: got %b expected 1", f_ovf);
        end
        wait_fast_idle(ok);
        checks++;
        if (!ok || rx_q.size() != 5) begin
            errors++;
            $display("FAIL setclr_rx_count: got %0d (idle=%b) expected 5", rx_q.size(), ok);
        end
        for (int i = 0; i < rx_q.size() && i < 5; i++) begin
            checks++;
            if (rx_q[i] !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL setclr_rx_byte: idx %0d got %02h expected %02h", i, rx_q[i], 8'h20 + 8'(i));
            end
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        $display("test_set_clear done: rx=%0d", rx_q.size());
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        rx_q.delete();
        dbg_tx = 1'b1;
        dbg_data = 8'h3C; tick();
        dbg_data = 8'hA1; tick();
        dbg_data = 8'hB2; tick();
        dbg_tx = 1'b0;
        repeat (33) tick();   // edge 36: inside data bit 3 of 0x3C
        checks++;
        if ({f_tx, f_busy} !== 2'b11) begin
            errors++;
            $display("FAIL midframe_pre: got tx,busy=%b expected 11", {f_tx, f_busy});
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_tx, f_busy, f_full, f_ovf} !== 4'b1000) begin
            errors++;
            $display("FAIL midframe_async: got tx,busy,full,ovf=%b expected 1000", {f_tx, f_busy, f_full, f_ovf});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (f_tx !== 1'b1 || f_busy !== 1'b0 || f_full !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL midframe_after: got %0d active cycles, %0d bytes expected 0, 0", bad, rx_q.size());
        end
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_stream(input string name, input logic [7:0] bytes[$], input int max_gap);
        bit ok;
        int i, guard;
        rx_q.delete();
        i = 0;
        guard = 0;
        while (i < bytes.size() && guard < 20000) begin
            if (!f_full) begin
                dbg_data = bytes[i];
                dbg_tx   = 1'b1;
                i++;
                tick();
                dbg_tx = 1'b0;
                repeat ($urandom_range(0, max_gap)) tick();
            end else begin
                tick();
            end
            guard++;
        end
        dbg_tx = 1'b0;
        wait_fast_idle(ok);
        checks++;
        if (!ok || i != bytes.size() || rx_q.size() != bytes.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d rx, %0d sent expected %0d", name, rx_q.size(), i, bytes.size());
        end
        for (int k = 0; k < rx_q.size() && k < bytes.size(); k++) begin
            checks++;
            if (rx_q[k] !== bytes[k]) begin
                errors++;
                $display("FAIL %s_byte: idx %0d got %02h expected %02h", name, k, rx_q[k], bytes[k]);
            end
        end
        checks++;
        if (f_ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovf: got %b expected 0", name, f_ovf);
        end
        $display("%s done: rx=%0d", name, rx_q.size());
    endtask

    task automatic test_pointer_wrap();
        logic [7:0] q[$];
        for (int i = 0; i < 20; i++) q.push_back(8'(i));
        test_stream("pointer_wrap", q, 0);
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom_range(0, 255)));
        test_stream("random_stream", q, 30);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_set_clear();
        test_reset_mid_frame();
        test_pointer_wrap();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_uart_tx.md
Name: dbg_uart_tx

Overview:
- Debug UART transmitter, downstream of the digital core's debug port (dbg_data / dbg_tx / dbg_done).
- Buffers debug bytes in a small FIFO and serialises them 8N1 on TX toward the Bluegiga module's RX line.
- Runs at clk = 50 MHz; baud rate is set by a divisor parameter.

Parameters:
- BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200).
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; must be a power of 2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- dbg_data  in  8  byte to transmit; sampled when dbg_tx=1
- dbg_tx  in  1  write strobe, one cycle per byte
- clr_ovf  in  1  clears the ovf flag
- TX  out  1  serial output, idle high
- dbg_done  out  1  1-cycle pulse at end of each frame's stop bit
- full  out  1  FIFO holds FIFO_DEPTH entries
- busy  out  1  frame in progress or FIFO non-empty
- ovf  out  1  sticky: a write was dropped

Behaviour:
- Reset values: TX=1, dbg_done=0, full=0, busy=0, ovf=0, FIFO empty, FSM in IDLE, baud counter 0, bit counter 0.
- Reset mid-frame: TX returns to 1 immediately (asynchronous); the FIFO contents are discarded.
- FIFO write:
  - On a clk edge with dbg_tx=1 and full=0, dbg_data is written at wr_ptr.
  - full is evaluated before any same-cycle pop.
  - A write while full is dropped and sets ovf, even if a pop occurs in the same cycle.
- Pointers: log2(FIFO_DEPTH)+1 bits each, wrapping naturally.
  - empty when the pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
- Overflow flag:
  - clr_ovf=1 clears ovf.
  - If clr_ovf and a dropped write occur in the same cycle, ovf ends at 1 (set wins).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If FIFO is non-empty, pop the head into shift_reg[7:0], clear the baud counter, go to START.
  - START: TX=0 for BAUD_DIV cycles, then go to DATA with bit_cnt=0.
  - DATA: TX=shift_reg[0], LSB first. Every BAUD_DIV cycles shift right and increment bit_cnt; after bit 7 completes go to STOP.
  - STOP: TX=1 for BAUD_DIV cycles. On the last cycle, pulse dbg_done. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency:
  - dbg_tx is asserted in cycle 0 with the FIFO empty and FSM in IDLE.
  - Write occurs at edge 1; pop and the FSM move to START occur at edge 2.
  - TX falls after edge 2.
- Frame length: exactly 10*BAUD_DIV cycles.
  - Back-to-back frames: stop bit of frame N is followed immediately by the start bit of frame N+1.
- Baud counter:
  - Counts 0..BAUD_DIV-1; the bit boundary is at terminal count.
  - Width is clog2(BAUD_DIV).
  - The counter holds at 0 in IDLE.
- busy = (state != IDLE) | !empty, registered-state based, combinational from FSM state and pointers.
- TX is driven from a flop (glitch-free output).
- dbg_tx asserted while a frame is in progress only enqueues; it never disturbs the current frame.

Decomposition:
- Shared package dbg_uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - localparam defaults: BAUD_DIV=434, FIFO_DEPTH=4.
  - Width helper constants for the baud counter and pointers.
- Sub-module dbg_fifo:
  - Synchronous FIFO with wr_en/rd_en/din/dout/full/empty.
  - Parameterised by depth.
  - Owns the pointers and the drop-when-full rule, plus an ovf_set output.
- dbg_uart_tx keeps the FSM, baud counter, bit counter, shift register and ovf flag.

Test Plan:
- Single byte, BAUD_DIV=434: write 0xA5 → TX low after 2 edges; bits 1,0,1,0,0,1,0,1 (LSB first) each 434 cycles; stop high 434 cycles; dbg_done pulses once at cycle 4341 after the write; busy drops the next cycle.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles → three frames totalling 13020 cycles with no idle gap; dbg_done pulses exactly 3 times, 4340 cycles apart.
- Overflow, BAUD_DIV=8: write 6 bytes 0x10..0x15 in 6 consecutive cycles while idle.
  - First byte is popped at edge 2, so 0x10..0x14 are accepted and the 6th write is dropped: ovf=1, full=1.
  - Output sequence is 0x10..0x14.
  - clr_ovf pulse → ovf=0.
- Simultaneous set/clear: with the FIFO full, assert dbg_tx and clr_ovf in the same cycle → ovf=1 afterwards, and the dropped byte never appears on TX.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0x3C with 2 bytes queued → TX=1 immediately; after release busy=0, full=0, and no further frames.
- Pointer wrap: stream 20 bytes 0x00..0x13, writing each only when full=0 → received bytes match in order, with no loss and no ovf.
